result_display: RTL and testbench

//  Consumer end of the calculator result interface: captures result[15:0] on each
//  ld_result strobe, converts it to BCD with a sequential double-dabble engine, and

---
 rtl/result_display.sv | 176 +++++++++++++++++
 tb/tb_result_display.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/result_display.sv
// Captures calculator results, converts them to BCD with a serial double-dabble engine,
// and scans the value onto a 4-digit active-low 7-segment display in decimal or hex.
module result_display #(
    parameter int SCAN_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] result,
    input  logic        ld_result,
    input  logic        dec_mode,
    output logic        busy,
    output logic [15:0] shown,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t        state_q, state_d;
    logic [15:0]   shift_q, shift_d;
    logic [19:0]   bcd_q, bcd_d, bcd_adj;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   val_q, val_d;
    logic [15:0]   shown_q, shown_d;
    logic [19:0]   dig_q, dig_d;
    logic          pend_q, pend_d;
    logic [15:0]   pval_q, pval_d;

    logic [SCAN_W-1:0] scan_q;
    logic [1:0]        idx_q;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        nib;
    logic              dash;

    function automatic logic [6:0] seg_enc(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < 5; k++) begin
            if (bcd_q[k*4 +: 4] >= 4'd5)
                bcd_adj[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        shown_d = shown_q;
        dig_d   = dig_q;
        pend_d  = pend_q;
        pval_d  = pval_q;
        case (state_q)
            IDLE: begin
                if (ld_result) begin
                    shift_d = result;
                    val_d   = result;
                    bcd_d   = 20'd0;
                    cnt_d   = 4'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d   = {bcd_adj[18:0], shift_q[15]};
                shift_d = {shift_q[14:0], 1'b0};
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd15)
                    state_d = COMMIT;
                if (ld_result) begin
                    pend_d = 1'b1;
                    pval_d = result;
                end
            end
            COMMIT: begin
                shown_d = val_q;
                dig_d   = bcd_q;
                bcd_d   = 20'd0;
                cnt_d   = 4'd0;
                // A load landing on the commit cycle is queued behind the pending one,
                // or started directly if nothing is pending, so it is never lost.
                if (pend_q) begin
                    shift_d = pval_q;
                    val_d   = pval_q;
                    state_d = CONV;
                    pend_d  = ld_result;
                    if (ld_result)
                        pval_d = result;
                end else if (ld_result) begin
                    shift_d = result;
                    val_d   = result;
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            val_q   <= '0;
            shown_q <= '0;
            dig_q   <= '0;
            pend_q  <= 1'b0;
            pval_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            shown_q <= shown_d;
            dig_q   <= dig_d;
            pend_q  <= pend_d;
            pval_q  <= pval_d;
        end
    end

    always_comb begin
        dash  = dec_mode && (dig_q[19:16] != 4'd0);
        nib   = dec_mode ? dig_q[{idx_q, 2'b00} +: 4] : shown_q[{idx_q, 2'b00} +: 4];
        seg_d = dash ? 7'b0111111 : seg_enc(nib);
        an_d  = ~(4'b0001 << idx_q);
    end

    // an and seg share one register stage so a digit switch never shows the wrong pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q <= '0;
            idx_q  <= 2'd0;
            an_q   <= 4'b1111;
            seg_q  <= 7'b1111111;
        end else begin
            scan_q <= scan_q + 1'b1;
            if (scan_q == {SCAN_W{1'b1}})
                idx_q <= idx_q + 2'd1;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign shown = shown_q;
    assign an    = an_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display with a fast scan prescaler.
module tb_result_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] result;
    logic        ld_result;
    logic        dec_mode;
    logic        busy;
    logic [15:0] shown;
    logic [3:0]  an;
    logic [6:0]  seg;

    int total = 0;
    int bad   = 0;

    result_display #(.SCAN_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .result    (result),
        .ld_result (ld_result),
        .dec_mode  (dec_mode),
        .busy      (busy),
        .shown     (shown),
        .an        (an),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        logic        dec;
        logic        reload;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S7 = 7'b1111000,
                           S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011,
                           SD = 7'b0100001, SF = 7'b0001110, SM = 7'b0111111;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [15:0] v);
        result    = v;
        ld_result = 1'b1;
        tick();
        ld_result = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic read_digits(input string name, input logic [27:0] exp);
        logic [3:0] pat;
        int         w;
        for (int i = 0; i < 4; i++) begin
            pat = ~(4'b0001 << i);
            w = 0;
            while (an !== pat && w < 20) begin
                w++;
                tick();
            end
            if (an !== pat) begin
                total++;
                bad++;
                $display("FAIL %s digit%0d: an never reached %b (got %b)", name, i, pat, an);
            end else begin
                check($sformatf("%s seg%0d", name, i), {25'd0, seg}, {25'd0, exp[i*7 +: 7]});
            end
        end
    endtask

    initial begin
        int n;
        logic seen100, seen200, gap;

        vecs[0] = '{16'd1234,  1'b1, 1'b1, {S1, S2, S3, S4}};
        vecs[1] = '{16'd1234,  1'b0, 1'b0, {S0, S4, SD, S2}};
        vecs[2] = '{16'd12345, 1'b1, 1'b1, {SM, SM, SM, SM}};
        vecs[3] = '{16'd12345, 1'b0, 1'b0, {S3, S0, S3, S9}};
        vecs[4] = '{16'hFFFF,  1'b0, 1'b1, {SF, SF, SF, SF}};
        vecs[5] = '{16'hFFFF,  1'b1, 1'b0, {SM, SM, SM, SM}};
        vecs[6] = '{16'd9999,  1'b1, 1'b1, {S9, S9, S9, S9}};
        vecs[7] = '{16'd171,   1'b0, 1'b1, {S0, S0, SA, SB}};
        vecs[8] = '{16'd171,   1'b1, 1'b0, {S0, S1, S7, S1}};

        rst = 1'b1; result = '0; ld_result = 1'b0; dec_mode = 1'b1;

        // Reset and idle scan of 0000
        repeat (3) tick();
        check("rst an", {28'd0, an}, 32'hF);
        check("rst seg", {25'd0, seg}, 32'h7F);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst shown", {16'd0, shown}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("scan an k=%0d", k), {28'd0, an}, {28'd0, ~(4'b0001 << (k / 4))});
            check($sformatf("scan seg k=%0d", k), {25'd0, seg}, {25'd0, S0});
        end

        // Table of loads and mode switches
        for (int v = 0; v < 9; v++) begin
            dec_mode = vecs[v].dec;
            if (vecs[v].reload) begin
                load(vecs[v].val);
                wait_idle(n);
                check($sformatf("v%0d busy cycles", v), n, 17);
            end else begin
                tick();
                check($sformatf("v%0d no reconversion", v), {31'd0, busy}, 32'd0);
            end
            tick();
            check($sformatf("v%0d shown", v), {16'd0, shown}, {16'd0, vecs[v].val});
            read_digits($sformatf("v%0d", v), vecs[v].segs);
        end

        // Chained loads: 200 is overwritten by 300 while 100 converts
        dec_mode = 1'b1;
        load(16'd0);
        wait_idle(n);
        load(16'd100);
        tick();
        load(16'd200);
        tick();
        tick();
        load(16'd300);
        seen100 = 1'b0; seen200 = 1'b0; gap = 1'b0;
        n = 0;
        while (shown !== 16'd300 && n < 100) begin
            if (!busy) gap = 1'b1;
            if (shown === 16'd100) seen100 = 1'b1;
            if (shown === 16'd200) seen200 = 1'b1;
            n++;
            tick();
        end
        check("chain final shown", {16'd0, shown}, 32'd300);
        check("chain saw 100", {31'd0, seen100}, 32'd1);
        check("chain never 200", {31'd0, seen200}, 32'd0);
        check("chain busy continuous", {31'd0, gap}, 32'd0);
        check("chain busy drops at commit", {31'd0, busy}, 32'd0);
        tick();
        read_digits("chain", {S0, S3, S0, S0});

        // Reset during conversion aborts it
        load(16'd9999);
        repeat (7) tick();
        check("abort busy before rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort shown", {16'd0, shown}, 32'd0);
        repeat (30) tick();
        check("abort no commit busy", {31'd0, busy}, 32'd0);
        check("abort no commit shown", {16'd0, shown}, 32'd0);
        read_digits("abort", {S0, S0, S0, S0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
